pipeline_hazard_sched: RTL and testbench
========================================

# pipeline_hazard_sched

Hazard scheduler for the five-stage pipelined CPU (IF/ID/EX/MEM/WB). It keeps a three-entry scoreboard of in-flight register writes for the EX, MEM and WB stages. From that scoreboard and the decoded ID-stage fields it drives:
- PC and IFID hold (stall),
- IDEX bubble insertion,
- flushes when a branch is taken in MEM,
- registered forwarding selects for the EX-stage ALU operands (when forwarding is compiled in).

It sits beside the pipeline registers and owns no datapath.

## Interface
- REG_NUM_WIDTH, 5, register-number width
- CNT_WIDTH, 16, width of the stall and flush event counters
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- idValid  in  1  ID holds a real instruction (0 = bubble)
- idRS  in  REG_NUM_WIDTH  rs field of the ID instruction
- idRT  in  REG_NUM_WIDTH  rt field of the ID instruction
- idUsesRS  in  1  ID instruction reads rs
- idUsesRT  in  1  ID instruction reads rt
- idRegWrite  in  1  ID instruction writes a register
- idWrNum  in  REG_NUM_WIDTH  destination register (rd or rt, already selected)
- idMemRead  in  1  ID instruction is a load
- branchTaken  in  1  MEM-stage branch is taken (branch AND isEqual)
- pcHold  out  1  PC keeps its value this cycle
- ifidHold  out  1  IFID keeps its value this cycle
- idexBubble  out  1  IDEX loads all-zero control (nop)
- flushIFID  out  1  IFID clears to nop
- flushIDEX  out  1  IDEX clears to nop
- flushEXMEM  out  1  EXMEM clears to nop
- fwdA  out  2  EX operand A source: 0 register file, 1 EXMEM ALU output, 2 MEMWB write data
- fwdB  out  2  EX operand B source, same encoding as fwdA
- schedState  out  2  last action taken: 0 RUN, 1 STALL, 2 FLUSH
- stallCount  out  CNT_WIDTH  saturating count of stall cycles
- flushCount  out  CNT_WIDTH  saturating count of flush cycles

## Operation
**Scoreboard**
- Entries sbEX, sbMEM and sbWB, each holding {valid, regNum, isLoad}.
- An entry matches a source register when:
  - the entry is valid,
  - regNum equals the source register,
  - the source register is not 0,
  - the corresponding idUses* input is 1.

**Hazard check (`FWD_EN` undefined)**
- hazard = idValid AND (any source register matches sbEX, sbMEM or sbWB).

**Hazard check (`FWD_EN` defined)**
- hazard = idValid AND any of:
  - a source register matches sbEX and sbEX.isLoad = 1;
  - a source register matches sbWB and matches neither sbEX nor sbMEM.
- The sbWB case stalls because register-file writes at a clock edge are not visible to the same-cycle ID read.

**Priority**
- branchTaken > hazard > normal advance.
- FLUSH:
  - flushIFID, flushIDEX and flushEXMEM are 1; pcHold, ifidHold and idexBubble are 0.
  - Next scoreboard: sbWB ← sbMEM, sbMEM ← invalid, sbEX ← invalid.
- STALL:
  - pcHold, ifidHold and idexBubble are 1.
  - Next scoreboard: sbWB ← sbMEM, sbMEM ← sbEX, sbEX ← invalid.
- RUN:
  - All hold and flush outputs are 0.
  - Next scoreboard: sbWB ← sbMEM, sbMEM ← sbEX.
  - sbEX ← {idValid AND idRegWrite AND idWrNum≠0, idWrNum, idMemRead}.

**Forwarding selects**
- Registered, and computed from ID-stage state in RUN only.
- Youngest producer wins: a match on sbEX gives 1, a match on sbMEM gives 2, otherwise 0.
- fwdA and fwdB clear to 0 on STALL or FLUSH, because a bubble enters EX.

**State and counters**
- schedState registers the cycle's action.
- stallCount increments on each STALL cycle; flushCount increments on each FLUSH cycle.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Hold, bubble and flush outputs are combinational from the registered scoreboard and the current ID inputs, with zero-cycle latency. They are valid before the same clk edge that the pipeline registers sample.
- fwdA/fwdB, schedState and the counters update on the rising edge of clk and are valid for the instruction now in EX.
- A load-use dependency costs exactly 1 stall cycle with `FWD_EN` and up to 3 without it.
- A taken branch costs 3 flushed slots. branchTaken is expected for one cycle; if it stays high, each high cycle flushes again.
- branchTaken together with a hazard resolves as FLUSH: the stalled instruction is discarded and stallCount is not incremented.
- On rst low, asynchronously:
  - scoreboard entries are invalid; fwdA = fwdB = 0; schedState = RUN; both counters = 0.
  - Consequently, pcHold = ifidHold = idexBubble = 0 and the flush outputs = 0 while branchTaken = 0.
- Reset asserted mid-stall abandons the stall immediately. No state survives reset.

## Configuration
- `FWD_EN` defined:
  - forwarding selects are generated;
  - only load-use matches on sbEX, and WB-only matches, stall.
- `FWD_EN` undefined:
  - fwdA and fwdB are tied to 0;
  - any valid scoreboard match stalls until the producer leaves WB.

## Test plan
- Reset with rst=0 while clk runs, then release: all outputs 0, schedState=0 and both counters 0 until the first ID instruction.
- add r3 then add r4,r3,r1 back-to-back:
  - with `FWD_EN`: no stall, and fwdA=1 the next cycle;
  - without: pcHold=1 for 3 cycles and stallCount=3.
- lw r5 then sub r6,r5,r2 with `FWD_EN`: exactly 1 stall cycle with idexBubble=1, then fwdA=2 when sub enters EX.
- Writer to r0 followed by a reader of r0: no stall and fwdA=fwdB=0.
- branchTaken=1 while ID has a hazard: flush outputs =1, pcHold=0, flushCount=1, stallCount unchanged, and sbEX and sbMEM invalid the next cycle.
- Force 65540 consecutive stalls with CNT_WIDTH=16: stallCount holds at 65535 and does not wrap.

Source files
------------

// File: rtl/pipeline_hazard_sched.sv
// Hazard scheduler: in-flight write scoreboard driving stall, bubble, flush and EX forwarding selects.
// Optional macro FWD_EN compiles in operand forwarding and relaxes the stall rule to load-use/WB-only.
module pipeline_hazard_sched #(
  parameter int REG_NUM_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idValid,
  input  logic [REG_NUM_WIDTH-1:0] idRS,
  input  logic [REG_NUM_WIDTH-1:0] idRT,
  input  logic                     idUsesRS,
  input  logic                     idUsesRT,
  input  logic                     idRegWrite,
  input  logic [REG_NUM_WIDTH-1:0] idWrNum,
  input  logic                     idMemRead,
  input  logic                     branchTaken,
  output logic                     pcHold,
  output logic                     ifidHold,
  output logic                     idexBubble,
  output logic                     flushIFID,
  output logic                     flushIDEX,
  output logic                     flushEXMEM,
  output logic [1:0]               fwdA,
  output logic [1:0]               fwdB,
  output logic [1:0]               schedState,
  output logic [CNT_WIDTH-1:0]     stallCount,
  output logic [CNT_WIDTH-1:0]     flushCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } sched_t;

  typedef struct packed {
    logic                     valid;
    logic [REG_NUM_WIDTH-1:0] reg_num;
    logic                     is_load;
  } sb_t;

  localparam int SB_EX  = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;

  sb_t                  sb_reg  [3];
  sb_t                  sb_next [3];
  sched_t               state_reg, state_next;
  logic [1:0]           fwd_a_reg, fwd_a_next;
  logic [1:0]           fwd_b_reg, fwd_b_next;
  logic [CNT_WIDTH-1:0] stall_cnt_reg, flush_cnt_reg;
  logic [2:0]           match_rs, match_rt;
  logic                 hazard;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign match_rs[gi] = sb_reg[gi].valid && idUsesRS && (idRS != '0) && (sb_reg[gi].reg_num == idRS);
      assign match_rt[gi] = sb_reg[gi].valid && idUsesRT && (idRT != '0) && (sb_reg[gi].reg_num == idRT);
    end
  endgenerate

`ifdef FWD_EN
  logic hz_rs, hz_rt;
  logic unused_load;

  // A WB-only producer still stalls: the register file write lands too late for this ID read.
  assign hz_rs = (match_rs[SB_EX] && sb_reg[SB_EX].is_load) ||
                 (match_rs[SB_WB] && !match_rs[SB_EX] && !match_rs[SB_MEM]);
  assign hz_rt = (match_rt[SB_EX] && sb_reg[SB_EX].is_load) ||
                 (match_rt[SB_WB] && !match_rt[SB_EX] && !match_rt[SB_MEM]);
  assign hazard      = idValid && (hz_rs || hz_rt);
  assign unused_load = ^{sb_reg[SB_MEM].is_load, sb_reg[SB_WB].is_load};

  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return 2'd1;
    if (hit_mem) return 2'd2;
    return 2'd0;
  endfunction
`else
  logic unused_load;

  assign hazard      = idValid && ((|match_rs) || (|match_rt));
  assign unused_load = ^{sb_reg[SB_EX].is_load, sb_reg[SB_MEM].is_load, sb_reg[SB_WB].is_load};
`endif

  always_comb begin
    state_next  = ST_RUN;
    pcHold      = 1'b0;
    ifidHold    = 1'b0;
    idexBubble  = 1'b0;
    flushIFID   = 1'b0;
    flushIDEX   = 1'b0;
    flushEXMEM  = 1'b0;
    fwd_a_next  = 2'd0;
    fwd_b_next  = 2'd0;
    sb_next[SB_WB]          = sb_reg[SB_MEM];
    sb_next[SB_MEM]         = sb_reg[SB_EX];
    sb_next[SB_EX].valid    = idValid && idRegWrite && (idWrNum != '0);
    sb_next[SB_EX].reg_num  = idWrNum;
    sb_next[SB_EX].is_load  = idMemRead;

    if (branchTaken) begin
      state_next      = ST_FLUSH;
      flushIFID       = 1'b1;
      flushIDEX       = 1'b1;
      flushEXMEM      = 1'b1;
      sb_next[SB_MEM] = '0;
      sb_next[SB_EX]  = '0;
    end else if (hazard) begin
      state_next     = ST_STALL;
      pcHold         = 1'b1;
      ifidHold       = 1'b1;
      idexBubble     = 1'b1;
      sb_next[SB_EX] = '0;
    end

`ifdef FWD_EN
    if (state_next == ST_RUN && idValid) begin
      fwd_a_next = fwd_sel(match_rs[SB_EX], match_rs[SB_MEM]);
      fwd_b_next = fwd_sel(match_rt[SB_EX], match_rt[SB_MEM]);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) sb_reg[i] <= '0;
      state_reg     <= ST_RUN;
      fwd_a_reg     <= 2'd0;
      fwd_b_reg     <= 2'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      for (int i = 0; i < 3; i++) sb_reg[i] <= sb_next[i];
      state_reg <= state_next;
      fwd_a_reg <= fwd_a_next;
      fwd_b_reg <= fwd_b_next;
      if (state_next == ST_STALL && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      if (state_next == ST_FLUSH && flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign fwdA       = fwd_a_reg;
  assign fwdB       = fwd_b_reg;
  assign schedState = state_reg;
  assign stallCount = stall_cnt_reg;
  assign flushCount = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_sched.sv
// Directed bench for pipeline_hazard_sched; expectations follow FWD_EN when the bench is built with it.
// A second instance with 4-bit counters exercises counter saturation in a short run.
module tb_pipeline_hazard_sched;
`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       idValid, idUsesRS, idUsesRT, idRegWrite, idMemRead, branchTaken;
  logic [4:0] idRS, idRT, idWrNum;
  logic       pcHold, ifidHold, idexBubble, flushIFID, flushIDEX, flushEXMEM;
  logic [1:0] fwdA, fwdB, schedState;
  logic [15:0] stallCount, flushCount;

  logic       unused_s_pc, unused_s_ifid, unused_s_bub, unused_s_f1, unused_s_f2, unused_s_f3;
  logic [1:0] unused_s_fa, unused_s_fb, unused_s_st;
  logic [3:0] sat_stall, sat_flush;

  int checks = 0, errors = 0;
  int exp_stall = 0, exp_flush = 0;

  always #5 clk = ~clk;

  pipeline_hazard_sched dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRS(idRS), .idRT(idRT),
    .idUsesRS(idUsesRS), .idUsesRT(idUsesRT), .idRegWrite(idRegWrite), .idWrNum(idWrNum),
    .idMemRead(idMemRead), .branchTaken(branchTaken), .pcHold(pcHold), .ifidHold(ifidHold),
    .idexBubble(idexBubble), .flushIFID(flushIFID), .flushIDEX(flushIDEX), .flushEXMEM(flushEXMEM),
    .fwdA(fwdA), .fwdB(fwdB), .schedState(schedState), .stallCount(stallCount), .flushCount(flushCount)
  );

  pipeline_hazard_sched #(.REG_NUM_WIDTH(5), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .idValid(idValid), .idRS(idRS), .idRT(idRT),
    .idUsesRS(idUsesRS), .idUsesRT(idUsesRT), .idRegWrite(idRegWrite), .idWrNum(idWrNum),
    .idMemRead(idMemRead), .branchTaken(branchTaken), .pcHold(unused_s_pc), .ifidHold(unused_s_ifid),
    .idexBubble(unused_s_bub), .flushIFID(unused_s_f1), .flushIDEX(unused_s_f2), .flushEXMEM(unused_s_f3),
    .fwdA(unused_s_fa), .fwdB(unused_s_fb), .schedState(unused_s_st), .stallCount(sat_stall), .flushCount(sat_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] wr, input logic mr);
    idValid = v; idRS = rs; idRT = rt; idUsesRS = urs; idUsesRT = urt;
    idRegWrite = rw; idWrNum = wr; idMemRead = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pcHold"}, pcHold, 0);
    chk({tag, "_ifidHold"}, ifidHold, 0);
    chk({tag, "_bubble"}, idexBubble, 0);
    chk({tag, "_flush"}, {flushIFID, flushIDEX, flushEXMEM}, 0);
    chk({tag, "_fwd"}, {fwdA, fwdB}, 0);
    chk({tag, "_state"}, schedState, 0);
    chk({tag, "_counts"}, {stallCount, flushCount}, 0);
  endtask

  // Producer, optional idle gap, then a consumer; counts stall cycles and checks the forward select.
  task automatic pair(input string tag, input logic [4:0] p_wr, input logic p_ld, input int gap,
                      input logic [4:0] c_rs, input logic [4:0] c_rt, input logic c_urs, input logic c_urt,
                      input int exp_st, input int exp_fa, input int exp_fb);
    int stalls;
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, p_wr, p_ld);
    #1;
    chk({tag, "_prod_hold"}, pcHold, 0);
    repeat (gap) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    set_id(1'b1, c_rs, c_rt, c_urs, c_urt, 1'b1, 5'd20, 1'b0);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (!pcHold) break;
      chk({tag, "_bubble"}, idexBubble, 1);
      stalls++;
      @(negedge clk);
    end
    chk({tag, "_stalls"}, stalls, exp_st);
    exp_stall += exp_st;
    chk({tag, "_stall_count"}, stallCount, exp_stall);
    chk({tag, "_state"}, schedState, (exp_st > 0) ? 1 : 0);
    @(negedge clk);
    idle();
    #1;
    chk({tag, "_fwdA"}, fwdA, exp_fa);
    chk({tag, "_fwdB"}, fwdB, exp_fb);
    $display("txn %s: stalls=%0d fwdA=%0d fwdB=%0d", tag, stalls, fwdA, fwdB);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    idle();
    branchTaken = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset_active");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("reset_released");
    $display("txn reset: state=%0d stall=%0d flush=%0d", schedState, stallCount, flushCount);

    pair("add_add_rs",   5'd3,  1'b0, 0, 5'd3,  5'd1,  1'b1, 1'b1, FWD ? 0 : 3, FWD ? 1 : 0, 0);
    pair("lw_use",       5'd5,  1'b1, 0, 5'd5,  5'd2,  1'b1, 1'b1, FWD ? 1 : 3, FWD ? 2 : 0, 0);
    pair("r0_dep",       5'd0,  1'b0, 0, 5'd0,  5'd0,  1'b1, 1'b1, 0, 0, 0);
    pair("add_add_rt",   5'd7,  1'b0, 0, 5'd1,  5'd7,  1'b1, 1'b1, FWD ? 0 : 3, 0, FWD ? 1 : 0);
    pair("mem_dep",      5'd9,  1'b0, 1, 5'd9,  5'd9,  1'b1, 1'b1, FWD ? 0 : 2, FWD ? 2 : 0, FWD ? 2 : 0);
    pair("wb_dep",       5'd11, 1'b0, 2, 5'd11, 5'd0,  1'b1, 1'b0, 1, 0, 0);
    pair("lw_mem_dep",   5'd12, 1'b1, 1, 5'd12, 5'd0,  1'b1, 1'b0, FWD ? 0 : 2, FWD ? 2 : 0, 0);
    pair("rt_not_used",  5'd13, 1'b0, 0, 5'd1,  5'd13, 1'b1, 1'b0, 0, 0, 0);

    // Taken branch while ID has a load-use hazard.
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd21, 1'b0);
    branchTaken = 1'b1;
    #1;
    chk("br_flush", {flushIFID, flushIDEX, flushEXMEM}, 3'b111);
    chk("br_holds", {pcHold, ifidHold, idexBubble}, 3'b000);
    exp_flush++;
    @(negedge clk);
    branchTaken = 1'b0;
    #1;
    chk("br_flush_count", flushCount, exp_flush);
    chk("br_stall_count", stallCount, exp_stall);
    chk("br_state", schedState, 2);
    chk("br_sbex_cleared", pcHold, 0);
    @(negedge clk);
    idle();
    #1;
    chk("br_sbmem_cleared_fwd", fwdA, 0);
    chk("br_state_run", schedState, 0);
    $display("txn branch: flushCount=%0d stallCount=%0d", flushCount, stallCount);
    repeat (4) @(negedge clk);

    // Self-dependent load held in ID: repeated stalls saturate the narrow counter.
    @(negedge clk);
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    repeat (40) @(negedge clk);
    idle();
    exp_stall += FWD ? 20 : 30;
    #1;
    chk("stall_count_run", stallCount, exp_stall);
    chk("stall_sat", sat_stall, (exp_stall > 15) ? 15 : exp_stall);
    $display("txn stall_burst: stallCount=%0d sat=%0d", stallCount, sat_stall);
    repeat (4) @(negedge clk);

    branchTaken = 1'b1;
    repeat (20) @(negedge clk);
    branchTaken = 1'b0;
    exp_flush += 20;
    #1;
    chk("flush_count_run", flushCount, exp_flush);
    chk("flush_sat", sat_flush, (exp_flush > 15) ? 15 : exp_flush);
    chk("stall_sat_held", sat_stall, 15);
    $display("txn flush_burst: flushCount=%0d sat=%0d", flushCount, sat_flush);
    repeat (2) @(negedge clk);

    // Reset in the middle of a stall.
    @(negedge clk);
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
    @(negedge clk);
    set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd22, 1'b0);
    #1;
    chk("midstall_hold", pcHold, 1);
    rst = 1'b0;
    #1;
    chk_quiet("midstall_reset");
    @(negedge clk);
    #1;
    chk("midstall_reset_held", {pcHold, stallCount}, 0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("after_reset");
    $display("txn midstall_reset: pcHold=%0d stallCount=%0d", pcHold, stallCount);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
